// File: rtl/pad_event_scheduler.sv
// Round-robin scheduler sharing four RGB LEDs between four pad buttons.
// Each granted pad plays a five-frame sweep, then a blank guard gap.
module pad_event_scheduler #(
    parameter int TICK_DIV = 4,
    parameter int GAP_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] button_inp,
    input  logic       abort,
    output logic       led_1_R,
    output logic       led_1_G,
    output logic       led_1_B,
    output logic       led_2_R,
    output logic       led_2_G,
    output logic       led_2_B,
    output logic       led_3_R,
    output logic       led_3_G,
    output logic       led_3_B,
    output logic       led_4_R,
    output logic       led_4_G,
    output logic       led_4_B,
    output logic       busy,
    output logic [1:0] grant_id
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);

    state_t      r_state, w_state;
    logic [3:0]  r_btn_q;
    logic [3:0]  r_pend, w_pend;
    logic [1:0]  r_last, w_last;
    logic [1:0]  r_grant, w_grant;
    logic [7:0]  r_tick, w_tick;
    logic [2:0]  r_frame, w_frame;
    logic [7:0]  r_gap, w_gap;
    logic [11:0] r_led, w_led;

    logic [3:0]  w_rise;
    logic [3:0]  w_clr;
    logic        w_found;
    logic [1:0]  w_win;
    logic [1:0]  w_idx;

    // LED vector for a pad colour and frame; bit 3*l+{0,1,2} is LED l+1 R/G/B
    function automatic logic [11:0] f_leds(input logic [1:0] pad,
                                           input logic [2:0] frame);
        logic [2:0]  c;
        logic [11:0] v;
        c = (pad == 2'd3) ? 3'b111 : (3'b001 << pad);
        v = '0;
        if (frame == 3'd4)
            v = {4{c}};
        else
            v[int'(frame) * 3 +: 3] = c;
        return v;
    endfunction

    assign w_rise = button_inp & ~r_btn_q;

    // Round-robin search starting one past the last granted pad
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_idx   = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && r_pend[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Next-state, counter, pending and LED computation
    always_comb begin
        w_state = r_state;
        w_last  = r_last;
        w_grant = r_grant;
        w_tick  = r_tick;
        w_frame = r_frame;
        w_gap   = r_gap;
        w_led   = r_led;
        w_clr   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state = S_PLAY;
                    w_grant = w_win;
                    w_last  = w_win;
                    w_clr   = 4'b0001 << w_win;
                    w_tick  = '0;
                    w_frame = '0;
                    w_led   = f_leds(w_win, 3'd0);
                end
            end
            S_PLAY: begin
                if (r_tick == TICK_LAST) begin
                    w_tick = '0;
                    if (r_frame == 3'd4) begin
                        w_state = S_GAP;
                        w_gap   = '0;
                        w_led   = '0;
                    end else begin
                        w_frame = r_frame + 3'd1;
                        w_led   = f_leds(r_grant, w_frame);
                    end
                end else begin
                    w_tick = r_tick + 8'd1;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST)
                    w_state = S_IDLE;
                else
                    w_gap = r_gap + 8'd1;
            end
            default: begin
                w_state = S_IDLE;
                w_led   = '0;
            end
        endcase
        // a new rise on the granted pad survives its own clear
        w_pend = (r_pend & ~w_clr) | w_rise;
        if (abort) begin
            w_state = S_IDLE;
            w_pend  = '0;
            w_led   = '0;
            w_grant = r_grant;
            w_last  = r_last;
        end
    end

    // State, counters, pending bits and registered LED lanes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_btn_q <= '0;
            r_pend  <= '0;
            r_last  <= 2'd3;
            r_grant <= 2'd0;
            r_tick  <= '0;
            r_frame <= '0;
            r_gap   <= '0;
            r_led   <= '0;
        end else begin
            r_state <= w_state;
            r_btn_q <= button_inp;
            r_pend  <= w_pend;
            r_last  <= w_last;
            r_grant <= w_grant;
            r_tick  <= w_tick;
            r_frame <= w_frame;
            r_gap   <= w_gap;
            r_led   <= w_led;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_grant;

    assign led_1_R = r_led[0];
    assign led_1_G = r_led[1];
    assign led_1_B = r_led[2];
    assign led_2_R = r_led[3];
    assign led_2_G = r_led[4];
    assign led_2_B = r_led[5];
    assign led_3_R = r_led[6];
    assign led_3_G = r_led[7];
    assign led_3_B = r_led[8];
    assign led_4_R = r_led[9];
    assign led_4_G = r_led[10];
    assign led_4_B = r_led[11];

endmodule

// File: tb/tb_pad_event_scheduler.sv
// Scoreboard bench for pad_event_scheduler at default parameters.
// Stimulus queues expected snapshots and grants; a monitor checks them.
module tb_pad_event_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] button_inp;
    logic       abort;
    logic       led_1_R, led_1_G, led_1_B;
    logic       led_2_R, led_2_G, led_2_B;
    logic       led_3_R, led_3_G, led_3_B;
    logic       led_4_R, led_4_G, led_4_B;
    logic       busy;
    logic [1:0] grant_id;

    pad_event_scheduler #(.TICK_DIV(4), .GAP_CYC(2)) dut (
        .clk(clk), .rst(rst), .button_inp(button_inp), .abort(abort),
        .led_1_R(led_1_R), .led_1_G(led_1_G), .led_1_B(led_1_B),
        .led_2_R(led_2_R), .led_2_G(led_2_G), .led_2_B(led_2_B),
        .led_3_R(led_3_R), .led_3_G(led_3_G), .led_3_B(led_3_B),
        .led_4_R(led_4_R), .led_4_G(led_4_G), .led_4_B(led_4_B),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int         c;
        logic [11:0] led;
        logic       bsy;
        logic [1:0] gid;
    } snap_t;

    typedef struct {
        int         c;
        logic [1:0] pad;
    } gr_t;

    snap_t sq[$];
    gr_t   gq[$];

    wire [11:0] leds = {led_4_B, led_4_G, led_4_R, led_3_B, led_3_G, led_3_R,
                        led_2_B, led_2_G, led_2_R, led_1_B, led_1_G, led_1_R};

    function automatic logic [11:0] pat(input int pad, input int frame);
        logic [11:0] v;
        v = '0;
        for (int l = 0; l < 4; l++) begin
            if (frame == 4 || frame == l) begin
                v[l*3+0] = (pad == 0) || (pad == 3);
                v[l*3+1] = (pad == 1) || (pad == 3);
                v[l*3+2] = (pad == 2) || (pad == 3);
            end
        end
        return v;
    endfunction

    task automatic push_snap(input int c, input logic [11:0] led,
                             input logic bsy, input logic [1:0] gid);
        snap_t s;
        s.c = c; s.led = led; s.bsy = bsy; s.gid = gid;
        sq.push_back(s);
    endtask

    task automatic push_grant(input int c, input logic [1:0] pad);
        gr_t g;
        g.c = c; g.pad = pad;
        gq.push_back(g);
    endtask

    // full sweep expectations for a grant at edge g
    task automatic push_sweep(input int pad, input int g);
        push_grant(g, 2'(pad));
        for (int k = 0; k < 5; k++) begin
            push_snap(g + 4*k, pat(pad, k), 1'b1, 2'(pad));
            push_snap(g + 4*k + 3, pat(pad, k), 1'b1, 2'(pad));
        end
        push_snap(g + 20, 12'h000, 1'b1, 2'(pad));
        push_snap(g + 22, 12'h000, 1'b0, 2'(pad));
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // monitor: snapshot and grant checks, sampled on the falling edge
    snap_t m_s;
    gr_t   m_g;
    logic  prev_busy = 1'b0;
    always @(negedge clk) begin
        while (sq.size() > 0 && sq[0].c <= cyc) begin
            m_s = sq.pop_front();
            total++;
            if (m_s.c != cyc || leds !== m_s.led || busy !== m_s.bsy ||
                grant_id !== m_s.gid) begin
                bad++;
                $display("FAIL snap@%0d: got cyc=%0d led=%03h busy=%b gid=%0d want led=%03h busy=%b gid=%0d",
                         m_s.c, cyc, leds, busy, grant_id, m_s.led, m_s.bsy, m_s.gid);
            end
        end
        if (busy === 1'b1 && prev_busy === 1'b0) begin
            total++;
            if (gq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_grant: cyc=%0d gid=%0d want none",
                         cyc, grant_id);
            end else begin
                m_g = gq.pop_front();
                if (cyc != m_g.c || grant_id !== m_g.pad ||
                    leds !== pat(int'(m_g.pad), 0)) begin
                    bad++;
                    $display("FAIL grant: got cyc=%0d gid=%0d led=%03h want cyc=%0d gid=%0d led=%03h",
                             cyc, grant_id, leds, m_g.c, m_g.pad,
                             pat(int'(m_g.pad), 0));
                end
            end
        end
        prev_busy = busy;
    end

    // asynchronous reset must clear outputs without a clock edge
    always @(negedge rst) begin
        #1;
        total++;
        if (leds !== 12'h000 || busy !== 1'b0 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL async_rst: got led=%03h busy=%b gid=%0d want led=000 busy=0 gid=0",
                     leds, busy, grant_id);
        end
    end

    initial begin
        rst = 1'b0;
        button_inp = 4'h0;
        abort = 1'b0;
        push_snap(4, 12'h000, 1'b0, 2'd0);
        wait_to(3);
        rst = 1'b1;

        // pads 0 and 2 together: pad 0 first, pad 2 23 edges later
        push_sweep(0, 12);
        push_sweep(2, 35);
        wait_to(10);
        button_inp = 4'b0101;
        wait_to(11);
        button_inp = 4'b0000;

        // single press on pad 1
        push_sweep(1, 62);
        wait_to(60);
        button_inp = 4'b0010;
        wait_to(61);
        button_inp = 4'b0000;

        // all pads pulsing: rotation continues from pad 2
        push_sweep(2, 92);
        push_sweep(3, 115);
        push_sweep(0, 138);
        push_sweep(1, 161);
        push_sweep(2, 184);
        push_sweep(3, 207);
        push_sweep(0, 230);
        push_sweep(1, 253);
        push_sweep(2, 276);
        for (int c = 90; c <= 200; c += 2) begin
            wait_to(c);
            button_inp = 4'hF;
            wait_to(c + 1);
            button_inp = 4'h0;
        end

        // re-trigger of pad 3 during its play, pad 1 served first
        push_sweep(3, 302);
        push_sweep(1, 325);
        push_sweep(3, 348);
        wait_to(300);
        button_inp = 4'b1000;
        wait_to(301);
        button_inp = 4'b0000;
        wait_to(305);
        button_inp = 4'b0010;
        wait_to(306);
        button_inp = 4'b0000;
        wait_to(308);
        button_inp = 4'b1000;
        wait_to(309);
        button_inp = 4'b0000;

        // abort in frame 2 with pads 0 and 1 pending
        push_grant(382, 2'd2);
        push_snap(382, pat(2, 0), 1'b1, 2'd2);
        push_snap(385, pat(2, 0), 1'b1, 2'd2);
        push_snap(386, pat(2, 1), 1'b1, 2'd2);
        push_snap(389, pat(2, 1), 1'b1, 2'd2);
        push_snap(390, pat(2, 2), 1'b1, 2'd2);
        push_snap(391, pat(2, 2), 1'b1, 2'd2);
        push_snap(392, 12'h000, 1'b0, 2'd2);
        push_snap(410, 12'h000, 1'b0, 2'd2);
        wait_to(380);
        button_inp = 4'b0100;
        wait_to(381);
        button_inp = 4'b0000;
        wait_to(384);
        button_inp = 4'b0011;
        wait_to(385);
        button_inp = 4'b0000;
        wait_to(391);
        abort = 1'b1;
        wait_to(392);
        abort = 1'b0;

        // reset mid-play, then a held button is one event on pad 0
        push_grant(422, 2'd0);
        push_snap(422, pat(0, 0), 1'b1, 2'd0);
        push_snap(425, pat(0, 0), 1'b1, 2'd0);
        push_snap(426, pat(0, 1), 1'b1, 2'd0);
        push_snap(429, pat(0, 1), 1'b1, 2'd0);
        push_snap(430, pat(0, 2), 1'b1, 2'd0);
        push_snap(432, 12'h000, 1'b0, 2'd0);
        push_sweep(0, 435);
        wait_to(420);
        button_inp = 4'b0001;
        wait_to(430);
        #2;
        rst = 1'b0;
        wait_to(433);
        rst = 1'b1;

        wait_to(480);
        total++;
        if (sq.size() != 0 || gq.size() != 0) begin
            bad++;
            $display("FAIL drain: got snaps=%0d grants=%0d left want 0 0",
                     sq.size(), gq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pad_event_scheduler.md
# pad_event_scheduler

Shares one bank of four RGB LEDs between four launch-pad buttons. A rising edge on a button queues a lighting event for that pad. A round-robin scheduler grants the LED bank to one pending pad at a time and plays a fixed five-frame sweep in that pad's colour, then blanks the bank for a guard gap before serving the next pad. It sits between the button inputs and the LED pins, in place of per-pad event blocks that drive the LEDs directly.

## Interface
- TICK_DIV, default 4: clock cycles per animation frame, legal range 1..255.
- GAP_CYC, default 2: LED-off cycles after each event, legal range 1..255.
- clk  in  1  rising-edge system clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- button_inp  in  4  pad buttons, synchronous to clk, level-high while pressed; bit i is pad i.
- abort  in  1  synchronous; when 1, drops the current event and all queued events.
- led_1_R, led_1_G, led_1_B  out  1 each  LED 1 colour lanes.
- led_2_R, led_2_G, led_2_B  out  1 each  LED 2 colour lanes.
- led_3_R, led_3_G, led_3_B  out  1 each  LED 3 colour lanes.
- led_4_R, led_4_G, led_4_B  out  1 each  LED 4 colour lanes.
- busy  out  1  high in PLAY and GAP.
- grant_id  out  2  pad currently being served; holds its last value when not busy.

## Operation
- Edge detect: btn_q (4 bits) registers button_inp. rise[i] = button_inp[i] & ~btn_q[i].
- Pending: each edge, pending[i] is set if rise[i] is 1. It is cleared when pad i is granted. If a grant of pad i and rise[i] happen in the same cycle, the set wins.
- Round-robin: search starts at pad last+1 mod 4 and takes the first pad with pending set. last updates to the granted pad.
- FSM states: IDLE, PLAY, GAP.
  - IDLE -> PLAY when any pending bit is set. On that transition: grant_id := winner; frame := 0; tick := 0.
  - PLAY: tick counts 0..TICK_DIV-1. When tick wraps, frame increments. When tick wraps while frame = 4, go to GAP with gap count := 0.
  - GAP: gap count counts 0..GAP_CYC-1, then go to IDLE.
- Pad colours: pad 0 red (R), pad 1 green (G), pad 2 blue (B), pad 3 white (R, G and B).
- Frames: frame k = 0..3 lights only LED k+1 in the granted pad's colour. Frame 4 lights all four LEDs. Every lane not lit is 0.
- In IDLE and GAP, all twelve LED outputs are 0.
- All LED outputs are registered and are loaded at the same clock edge as the state/frame update.
- Re-trigger: a rising edge on the pad currently being played queues a replay. The replay is served in round-robin order, not immediately.
- abort = 1 at an edge: state := IDLE, pending := 0, all LEDs := 0, busy := 0. abort has priority over every other transition. The edge detector keeps running during abort.
- A held button produces only one event. A new event needs a release followed by a press.

## Timing
- Reset (rst low, asynchronous): state IDLE, pending 0, btn_q 0, last 3 (so pad 0 is searched first), grant_id 0, tick/frame/gap counts 0, all LEDs 0, busy 0.
- A button already high when rst is released counts as a rise at the first edge.
- Latency: rise sampled at edge E0 -> pending set after E0 -> grant at E1. Frame 0 LEDs and busy=1 are visible after E1.
- Each frame is visible for TICK_DIV cycles, so PLAY lasts 5*TICK_DIV cycles.
- GAP lasts GAP_CYC cycles, then one IDLE cycle, then the next grant. With back-to-back pending requests, grants are spaced 5*TICK_DIV + GAP_CYC + 1 edges apart (23 at defaults).
- Pending bits are never lost while busy. A pad queues at most one event; repeat presses before its grant merge into that one event.

## Test plan
- Single press: pad 1 rises at E0 -> after E1, led_1_G=1 and busy=1, grant_id=1. Every 4 edges the single lit LED advances one position. After E17, all four G lanes are 1. After E21, all LEDs are 0 and busy=1. After E23, busy=0.
- Simultaneous presses of pads 0 and 2 at E0 -> pad 0 (red) granted at E1, pad 2 (blue) granted at E24.
- Fairness: all four pads pulse continuously -> grant order 0,1,2,3,0,… with no pad starved. Grant spacing is 23 edges.
- Re-trigger: pad 3 pressed again during its own PLAY while pad 1 is pending -> pad 1 is served next, then pad 3 replays in white.
- abort asserted in frame 2 with pads 0 and 1 pending -> at the next edge, LEDs are 0, busy=0, pending=0. No further grants occur without new presses.
- rst pulled low mid-PLAY -> all outputs are 0 immediately, without waiting for a clock edge. After release, a held button is taken as one new event on pad 0 at the first edge.
